// File: rtl/trigger_generator.sv
// ============================================================================
// trigger_generator
// ----------------------------------------------------------------------------
// Trigger sequencer that sits directly downstream of the trigger register
// interface. It turns start requests into trigger pulses that are delayed,
// grouped into bursts and optionally repeated periodically, all aligned to
// the sync strobe. Its outputs feed the ROC/TBM command encoder.
//
// A start request comes from a software pulse, a periodic tick or a pending
// external trigger. The sequencer waits 'delay' sync cycles, then fires
// max(burst,1) triggers spaced max(spacing,1) sync cycles apart.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   sync        clock enable; state only advances on clk edges with sync=1
//   ctrl        [0] run (periodic mode), [1] ext_en (external trigger enable)
//   pulse       one-sync-period pulses: [0] start, [1] count_clear, [2] abort
//   period      periodic start interval in sync cycles (0 = no periodic starts)
//   delay       sync cycles from start to the first trigger
//   burst       triggers per sequence (0 behaves as 1)
//   spacing     sync cycles between burst triggers (0 behaves as 1)
//   trig_in     external trigger, already synchronous to clk
//   trig        trigger output, high for one sync period per trigger
//   busy        a sequence is in progress
//   trig_count  total triggers fired, wraps at 2^32
//   missed      (only with TRIGGER_GEN_MISSED_EN) saturating count of start
//               requests dropped because the block was busy or aborting
//
// Build option:
//   TRIGGER_GEN_MISSED_EN  adds the 'missed' output and its counter.
// ============================================================================
module trigger_generator (
    input  logic        clk,
    input  logic        reset,
    input  logic        sync,
    input  logic [31:0] ctrl,
    input  logic [31:0] pulse,
    input  logic [31:0] period,
    input  logic [15:0] delay,
    input  logic [7:0]  burst,
    input  logic [7:0]  spacing,
    input  logic        trig_in,
    output logic        trig,
    output logic        busy,
`ifdef TRIGGER_GEN_MISSED_EN
    output logic [15:0] missed,
`endif
    output logic [31:0] trig_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] dcnt_q, dcnt_d;
    logic [7:0]  remaining_q, remaining_d;
    logic [31:0] pcnt_q, pcnt_d;
    logic        trig_q, trig_d;
    logic        busy_q, busy_d;
    logic [31:0] count_q, count_d;
    logic        extPending_q, extPending_d;
    logic        trigIn_q;

    logic        runEn;
    logic        periodTick;
    logic        extRise;
    logic        startReq;
    logic        fire;
    logic [7:0]  burstEff;
    logic [7:0]  spacingEff;

    // Control and pulse bits that this block does not use.
    logic        unusedBits;
    assign unusedBits = ^{ctrl[31:2], pulse[31:3]};

    // Zero burst/spacing values are treated as one.
    assign burstEff   = (burst   == 8'd0) ? 8'd1 : burst;
    assign spacingEff = (spacing == 8'd0) ? 8'd1 : spacing;

    // Periodic tick: pcnt runs 0..period-1 and ticks on the wrap, so the
    // first tick lands on the period-th sync edge after run is set.
    assign runEn      = ctrl[0] && (period != 32'd0);
    assign periodTick = runEn && (pcnt_q == period - 32'd1);

    // External rising edge, seen across consecutive clk samples.
    assign extRise    = trig_in && !trigIn_q && ctrl[1];

    assign startReq   = pulse[0] || periodTick || extPending_q;

`ifdef TRIGGER_GEN_MISSED_EN
    logic [15:0] missed_q, missed_d;
    logic        dropped;

    // A start is lost whenever it arrives while a sequence is running
    // (including the edge that returns to IDLE) or together with abort.
    assign dropped = sync && startReq && (pulse[2] || (state_q != IDLE));

    // Saturating miss counter; count_clear on a drop edge leaves it at 1,
    // mirroring how trig_count treats a clear on a fire edge.
    always_comb begin
        missed_d = missed_q;
        if (sync) begin
            if (pulse[1]) begin
                missed_d = dropped ? 16'd1 : 16'd0;
            end else if (dropped && (missed_q != 16'hFFFF)) begin
                missed_d = missed_q + 16'd1;
            end
        end
    end

    assign missed = missed_q;
`endif

    // Next-state logic for the sequencer. Everything except the external
    // edge capture is gated by sync; abort overrides fire and start.
    always_comb begin
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        remaining_d  = remaining_q;
        pcnt_d       = pcnt_q;
        trig_d       = trig_q;
        busy_d       = busy_q;
        count_d      = count_q;
        extPending_d = extPending_q;
        fire         = 1'b0;

        if (sync) begin
            if (!runEn) begin
                pcnt_d = 32'd0;
            end else if (periodTick) begin
                pcnt_d = 32'd0;
            end else begin
                pcnt_d = pcnt_q + 32'd1;
            end

            if (pulse[2]) begin
                state_d = IDLE;
                trig_d  = 1'b0;
                busy_d  = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        trig_d = 1'b0;
                        if (startReq) begin
                            dcnt_d      = delay;
                            remaining_d = burstEff;
                            state_d     = DELAY;
                            busy_d      = 1'b1;
                        end
                    end
                    DELAY, GAP: begin
                        if (dcnt_q == 16'd0) begin
                            fire        = 1'b1;
                            trig_d      = 1'b1;
                            count_d     = count_q + 32'd1;
                            remaining_d = remaining_q - 8'd1;
                            if (remaining_q == 8'd1) begin
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end else begin
                                dcnt_d  = {8'd0, spacingEff - 8'd1};
                                state_d = GAP;
                            end
                        end else begin
                            dcnt_d = dcnt_q - 16'd1;
                            trig_d = 1'b0;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        trig_d  = 1'b0;
                        busy_d  = 1'b0;
                    end
                endcase
            end

            // A clear on a fire edge keeps that fire in the count.
            if (pulse[1]) begin
                count_d = fire ? 32'd1 : 32'd0;
            end
        end

        // A new edge wins over the consuming sync edge so it is never lost.
        if (extRise) begin
            extPending_d = 1'b1;
        end else if (sync) begin
            extPending_d = 1'b0;
        end
    end

    // All sequencer state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            dcnt_q       <= 16'd0;
            remaining_q  <= 8'd0;
            pcnt_q       <= 32'd0;
            trig_q       <= 1'b0;
            busy_q       <= 1'b0;
            count_q      <= 32'd0;
            extPending_q <= 1'b0;
            trigIn_q     <= 1'b0;
`ifdef TRIGGER_GEN_MISSED_EN
            missed_q     <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            remaining_q  <= remaining_d;
            pcnt_q       <= pcnt_d;
            trig_q       <= trig_d;
            busy_q       <= busy_d;
            count_q      <= count_d;
            extPending_q <= extPending_d;
            trigIn_q     <= trig_in;
`ifdef TRIGGER_GEN_MISSED_EN
            missed_q     <= missed_d;
`endif
        end
    end

    assign trig       = trig_q;
    assign busy       = busy_q;
    assign trig_count = count_q;

endmodule

// File: tb/tb_trigger_generator.sv
// ============================================================================
// tb_trigger_generator
// ----------------------------------------------------------------------------
// Directed testbench for trigger_generator. Each task drives one scenario and
// compares trig/busy/trig_count against hand-derived per-edge patterns.
// Edge E0 is the sync edge that samples the start request; outputs are read
// 1 time unit after each clk rising edge.
// ============================================================================
module tb_trigger_generator;

   logic        clk = 1'b0;
   logic        reset;
   logic        sync;
   logic [31:0] ctrl;
   logic [31:0] pulse;
   logic [31:0] period;
   logic [15:0] delay;
   logic [7:0]  burst;
   logic [7:0]  spacing;
   logic        trig_in;
   logic        trig;
   logic        busy;
   logic [31:0] trig_count;
`ifdef TRIGGER_GEN_MISSED_EN
   logic [15:0] missed;
`endif

   int          errors = 0;
   int          checks = 0;
   logic [31:0] expCount = 32'd0;
   logic [15:0] expTrig;
   logic [15:0] expBusy;

   // Free-running system clock with a 10 time-unit period.
   always #5 clk = ~clk;

   trigger_generator dut (
      .clk        (clk),
      .reset      (reset),
      .sync       (sync),
      .ctrl       (ctrl),
      .pulse      (pulse),
      .period     (period),
      .delay      (delay),
      .burst      (burst),
      .spacing    (spacing),
      .trig_in    (trig_in),
      .trig       (trig),
      .busy       (busy),
`ifdef TRIGGER_GEN_MISSED_EN
      .missed     (missed),
`endif
      .trig_count (trig_count)
   );

   // Advance one clk edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold reset for two edges and check every output is at its reset value.
   task automatic test_reset();
      reset = 1'b1; sync = 1'b1; ctrl = 32'd0; pulse = 32'd0;
      period = 32'd0; delay = 16'd0; burst = 8'd1; spacing = 8'd1;
      trig_in = 1'b0;
      step(); step();
      checks++; if (trig !== 1'b0) begin errors++; $display("[TB] FAIL reset_trig: got %b expected 0", trig); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (trig_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", trig_count); end
`ifdef TRIGGER_GEN_MISSED_EN
      checks++; if (missed !== 16'd0) begin errors++; $display("[TB] FAIL reset_missed: got %0d expected 0", missed); end
`endif
      reset = 1'b0;
      step();
   endtask

   // One delayed trigger: delay=3, burst=1.
   task automatic test_single_shot();
      delay = 16'd3; burst = 8'd1; spacing = 8'd1;
      expTrig = 16'b0000_0000_0001_0000;
      expBusy = 16'b0000_0000_0000_1111;
      pulse = 32'd1;
      step();
      pulse = 32'd0;
      for (int e = 0; e < 7; e++) begin
         if (e > 0) step();
         checks++; if (trig !== expTrig[e]) begin errors++; $display("[TB] FAIL single_trig E%0d: got %b expected %b", e, trig, expTrig[e]); end
         checks++; if (busy !== expBusy[e]) begin errors++; $display("[TB] FAIL single_busy E%0d: got %b expected %b", e, busy, expBusy[e]); end
      end
      expCount = expCount + 32'd1;
      checks++; if (trig_count !== expCount) begin errors++; $display("[TB] FAIL single_count: got %0d expected %0d", trig_count, expCount); end
   endtask

   // Four triggers two sync cycles apart with no initial delay.
   task automatic test_burst();
      delay = 16'd0; burst = 8'd4; spacing = 8'd2;
      expTrig = 16'b0000_0000_1010_1010;
      expBusy = 16'b0000_0000_0111_1111;
      pulse = 32'd1;
      step();
      pulse = 32'd0;
      for (int e = 0; e < 10; e++) begin
         if (e > 0) step();
         checks++; if (trig !== expTrig[e]) begin errors++; $display("[TB] FAIL burst_trig E%0d: got %b expected %b", e, trig, expTrig[e]); end
         checks++; if (busy !== expBusy[e]) begin errors++; $display("[TB] FAIL burst_busy E%0d: got %b expected %b", e, busy, expBusy[e]); end
      end
      expCount = expCount + 32'd4;
      checks++; if (trig_count !== expCount) begin errors++; $display("[TB] FAIL burst_count: got %0d expected %0d", trig_count, expCount); end
   endtask

   // Zero burst and spacing must behave exactly like one.
   task automatic test_zero_params();
      delay = 16'd0; burst = 8'd0; spacing = 8'd0;
      expTrig = 16'b0000_0000_0000_0010;
      expBusy = 16'b0000_0000_0000_0001;
      pulse = 32'd1;
      step();
      pulse = 32'd0;
      for (int e = 0; e < 4; e++) begin
         if (e > 0) step();
         checks++; if (trig !== expTrig[e]) begin errors++; $display("[TB] FAIL zero_burst_trig E%0d: got %b expected %b", e, trig, expTrig[e]); end
         checks++; if (busy !== expBusy[e]) begin errors++; $display("[TB] FAIL zero_burst_busy E%0d: got %b expected %b", e, busy, expBusy[e]); end
      end
      expCount = expCount + 32'd1;
      burst = 8'd2;
      expTrig = 16'b0000_0000_0000_0110;
      expBusy = 16'b0000_0000_0000_0011;
      pulse = 32'd1;
      step();
      pulse = 32'd0;
      for (int e = 0; e < 5; e++) begin
         if (e > 0) step();
         checks++; if (trig !== expTrig[e]) begin errors++; $display("[TB] FAIL zero_space_trig E%0d: got %b expected %b", e, trig, expTrig[e]); end
         checks++; if (busy !== expBusy[e]) begin errors++; $display("[TB] FAIL zero_space_busy E%0d: got %b expected %b", e, busy, expBusy[e]); end
      end
      expCount = expCount + 32'd2;
      checks++; if (trig_count !== expCount) begin errors++; $display("[TB] FAIL zero_count: got %0d expected %0d", trig_count, expCount); end
   endtask

   // Periodic mode with period=10: ticks on edges 10,20,..,50 and each
   // trigger follows one edge later.
   task automatic test_periodic();
      logic expBit;
      delay = 16'd0; burst = 8'd1; spacing = 8'd1; period = 32'd10;
      ctrl = 32'd1;
      for (int k = 1; k <= 55; k++) begin
         step();
         expBit = (k > 1) && ((k % 10) == 1);
         checks++; if (trig !== expBit) begin errors++; $display("[TB] FAIL periodic_trig edge%0d: got %b expected %b", k, trig, expBit); end
      end
      ctrl = 32'd0;
      step();
      expCount = expCount + 32'd5;
      checks++; if (trig_count !== expCount) begin errors++; $display("[TB] FAIL periodic_count: got %0d expected %0d", trig_count, expCount); end
      step(); step();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL periodic_stop_busy: got %b expected 0", busy); end
   endtask

   // External triggers: rises at edges 1,5,9; the first starts a sequence
   // at edge 2 and the others are dropped. Then ext_en gating and the
   // pending edge surviving ext_en dropping are checked.
   task automatic test_external();
      delay = 16'd0; burst = 8'd3; spacing = 8'd5; period = 32'd0;
      ctrl = 32'd2;
      expTrig = 16'h2108;
      expBusy = 16'h1FFC;
      for (int k = 1; k <= 15; k++) begin
         trig_in = (k == 1) || (k == 5) || (k == 9);
         step();
         checks++; if (trig !== expTrig[k]) begin errors++; $display("[TB] FAIL ext_trig edge%0d: got %b expected %b", k, trig, expTrig[k]); end
         checks++; if (busy !== expBusy[k]) begin errors++; $display("[TB] FAIL ext_busy edge%0d: got %b expected %b", k, busy, expBusy[k]); end
      end
      trig_in = 1'b0;
      expCount = expCount + 32'd3;
      checks++; if (trig_count !== expCount) begin errors++; $display("[TB] FAIL ext_count: got %0d expected %0d", trig_count, expCount); end
`ifdef TRIGGER_GEN_MISSED_EN
      checks++; if (missed !== 16'd2) begin errors++; $display("[TB] FAIL ext_missed: got %0d expected 2", missed); end
`endif
      ctrl = 32'd0;
      step();
      trig_in = 1'b1;
      step();
      trig_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ext_disabled_busy %0d: got %b expected 0", k, busy); end
      end
      burst = 8'd1;
      sync = 1'b0;
      ctrl = 32'd2;
      trig_in = 1'b1;
      step();
      trig_in = 1'b0;
      ctrl = 32'd0;
      step();
      sync = 1'b1;
      step();
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ext_pending_busy: got %b expected 1", busy); end
      step();
      checks++; if (trig !== 1'b1) begin errors++; $display("[TB] FAIL ext_pending_trig: got %b expected 1", trig); end
      expCount = expCount + 32'd1;
      step();
      checks++; if (trig_count !== expCount) begin errors++; $display("[TB] FAIL ext_pending_count: got %0d expected %0d", trig_count, expCount); end
   endtask

   // Abort in the middle of a delay, start together with abort, and
   // count_clear both on a fire edge and on its own.
   task automatic test_abort_clear();
      delay = 16'd5; burst = 8'd1; spacing = 8'd1;
      pulse = 32'd1;
      step();
      pulse = 32'd0;
      step(); step();
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_pre_busy: got %b expected 1", busy); end
      pulse = 32'd4;
      step();
      pulse = 32'd0;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
      for (int e = 4; e < 10; e++) begin
         step();
         checks++; if (trig !== 1'b0) begin errors++; $display("[TB] FAIL abort_trig E%0d: got %b expected 0", e, trig); end
      end
      checks++; if (trig_count !== expCount) begin errors++; $display("[TB] FAIL abort_count: got %0d expected %0d", trig_count, expCount); end
      pulse = 32'd5;
      step();
      pulse = 32'd0;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_start_busy: got %b expected 0", busy); end
`ifdef TRIGGER_GEN_MISSED_EN
      checks++; if (missed !== 16'd3) begin errors++; $display("[TB] FAIL abort_missed: got %0d expected 3", missed); end
`endif
      delay = 16'd0;
      pulse = 32'd1;
      step();
      pulse = 32'd2;
      step();
      pulse = 32'd0;
      expCount = 32'd1;
      checks++; if (trig !== 1'b1) begin errors++; $display("[TB] FAIL clear_fire_trig: got %b expected 1", trig); end
      checks++; if (trig_count !== expCount) begin errors++; $display("[TB] FAIL clear_fire_count: got %0d expected %0d", trig_count, expCount); end
      pulse = 32'd2;
      step();
      pulse = 32'd0;
      expCount = 32'd0;
      checks++; if (trig_count !== expCount) begin errors++; $display("[TB] FAIL clear_count: got %0d expected %0d", trig_count, expCount); end
`ifdef TRIGGER_GEN_MISSED_EN
      checks++; if (missed !== 16'd0) begin errors++; $display("[TB] FAIL clear_missed: got %0d expected 0", missed); end
`endif
   endtask

   // State and outputs must only move on clk edges where sync is high.
   task automatic test_sync_enable();
      delay = 16'd1; burst = 8'd1; spacing = 8'd1;
      sync = 1'b0;
      pulse = 32'd1;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL sync_hold_idle %0d: got %b expected 0", k, busy); end
      end
      sync = 1'b1;
      step();
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL sync_e0_busy: got %b expected 1", busy); end
      pulse = 32'd0;
      sync = 1'b0;
      step(); step(); step();
      checks++; if (busy !== 1'b1 || trig !== 1'b0) begin errors++; $display("[TB] FAIL sync_gap_hold: got busy=%b trig=%b expected busy=1 trig=0", busy, trig); end
      sync = 1'b1;
      step();
      checks++; if (trig !== 1'b0) begin errors++; $display("[TB] FAIL sync_e1_trig: got %b expected 0", trig); end
      sync = 1'b0;
      step(); step();
      sync = 1'b1;
      step();
      checks++; if (trig !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL sync_e2: got trig=%b busy=%b expected trig=1 busy=0", trig, busy); end
      expCount = expCount + 32'd1;
      sync = 1'b0;
      step(); step();
      checks++; if (trig !== 1'b1) begin errors++; $display("[TB] FAIL sync_trig_hold: got %b expected 1", trig); end
      checks++; if (trig_count !== expCount) begin errors++; $display("[TB] FAIL sync_count: got %0d expected %0d", trig_count, expCount); end
      sync = 1'b1;
      step();
      checks++; if (trig !== 1'b0) begin errors++; $display("[TB] FAIL sync_trig_end: got %b expected 0", trig); end
   endtask

   // Asynchronous reset in the middle of a GAP, then a fresh single shot.
   task automatic test_reset_mid();
      delay = 16'd0; burst = 8'd3; spacing = 8'd4;
      pulse = 32'd1;
      step();
      pulse = 32'd0;
      step();
      checks++; if (trig !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre: got trig=%b busy=%b expected 1 1", trig, busy); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (trig !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_trig: got %b expected 0", trig); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_busy: got %b expected 0", busy); end
      checks++; if (trig_count !== 32'd0) begin errors++; $display("[TB] FAIL mid_reset_count: got %0d expected 0", trig_count); end
      step();
      reset = 1'b0;
      step();
      expCount = 32'd0;
      test_single_shot();
   endtask

   // Run every scenario in order and print the summary.
   initial begin
      test_reset();
      test_single_shot();
      test_burst();
      test_zero_params();
      test_periodic();
      test_external();
      test_abort_clear();
      test_sync_enable();
      test_reset_mid();
      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
